// File: rtl/symbol_downsampler_pkg.sv
// Shared definitions for the RX symbol downsampler and its TX-side counterpart.
package symbol_downsampler_pkg;

  localparam int unsigned DataWidth      = 4;
  localparam int unsigned DownsampleRate = 13;

  typedef enum logic [0:0] {
    StSearch = 1'b0,
    StLocked = 1'b1
  } state_e;

  // Counter width for a 0..n-1 range, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Free-running wrapping counter over 0..N-1 with a synchronous load.
module mod_counter
  import symbol_downsampler_pkg::*;
#(
  parameter int unsigned N     = 13,
  parameter int unsigned Width = cnt_width(N)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q == Width'(N - 1)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/symbol_downsampler.sv
// Recovers one symbol per period from a zero-stuffed sample stream, acquiring
// and tracking symbol phase from the position of nonzero samples.
module symbol_downsampler
  import symbol_downsampler_pkg::*;
#(
  parameter int unsigned DOWNSAMPLE_RATE = DownsampleRate,
  parameter int unsigned DATA_WIDTH      = DataWidth,
  parameter int unsigned ERR_LIMIT       = 3,
  parameter int unsigned ZERO_LIMIT      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  locked,
  output logic                  phase_err
);

  localparam int unsigned CntW  = cnt_width(DOWNSAMPLE_RATE);
  localparam int unsigned ErrW  = $clog2(ERR_LIMIT + 1);
  localparam int unsigned ZeroW = $clog2(ZERO_LIMIT + 1);

  state_e                state_d, state_q;
  logic [ErrW-1:0]       err_cnt_d, err_cnt_q;
  logic [ZeroW-1:0]      zero_cnt_d, zero_cnt_q;
  logic [DATA_WIDTH-1:0] data_out_d, data_out_q;
  logic                  valid_d, valid_q;
  logic                  perr_d, perr_q;
  logic                  cnt_load;
  logic [CntW-1:0]       phase;
  logic                  nonzero;

  // The sample that (re)defines phase 0 is consumed now, so the counter resumes at 1.
  mod_counter #(
    .N     (DOWNSAMPLE_RATE),
    .Width (CntW)
  ) u_phase_cnt (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (cnt_load),
    .load_val_i (CntW'(1)),
    .cnt_o      (phase)
  );

  assign nonzero = |data_in;

  always_comb begin
    state_d    = state_q;
    err_cnt_d  = err_cnt_q;
    zero_cnt_d = zero_cnt_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    perr_d     = 1'b0;
    cnt_load   = 1'b0;

    unique case (state_q)
      StSearch: begin
        if (nonzero) begin
          state_d    = StLocked;
          data_out_d = data_in;
          valid_d    = 1'b1;
          cnt_load   = 1'b1;
          err_cnt_d  = '0;
          zero_cnt_d = '0;
        end
      end
      StLocked: begin
        if (phase == '0) begin
          // A zero in the symbol slot is still a legitimate symbol.
          data_out_d = data_in;
          valid_d    = 1'b1;
          if (nonzero) begin
            err_cnt_d  = '0;
            zero_cnt_d = '0;
          end else if (zero_cnt_q == ZeroW'(ZERO_LIMIT - 1)) begin
            state_d    = StSearch;
            zero_cnt_d = '0;
          end else begin
            zero_cnt_d = zero_cnt_q + ZeroW'(1);
          end
        end else if (nonzero) begin
          perr_d = 1'b1;
          if (err_cnt_q == ErrW'(ERR_LIMIT - 1)) begin
            data_out_d = data_in;
            valid_d    = 1'b1;
            cnt_load   = 1'b1;
            err_cnt_d  = '0;
            zero_cnt_d = '0;
          end else begin
            err_cnt_d = err_cnt_q + ErrW'(1);
          end
        end
      end
      default: state_d = StSearch;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StSearch;
      err_cnt_q  <= '0;
      zero_cnt_q <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      err_cnt_q  <= err_cnt_d;
      zero_cnt_q <= zero_cnt_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = valid_q;
  assign locked     = (state_q == StLocked);
  assign phase_err  = perr_q;

endmodule

// File: tb/tb_symbol_downsampler.sv
// Directed and randomized checks of symbol_downsampler against a phase-anchor model.
module tb_symbol_downsampler;

  localparam int R  = 13;
  localparam int EL = 3;
  localparam int ZL = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] data_in = 4'h0;
  logic [3:0] data_out;
  logic       data_valid;
  logic       locked;
  logic       phase_err;

  int total = 0;
  int bad   = 0;

  // Model: phase is the distance in samples from the last anchor (phase-0 sample).
  bit         m_locked;
  int         anchor, errs, zeros, t;
  logic [3:0] e_out;
  bit         e_valid, e_perr;

  symbol_downsampler dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .locked     (locked),
    .phase_err  (phase_err)
  );

  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s @t=%0d: observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check1({tag, ".data_out"}, data_out, e_out);
    check1({tag, ".data_valid"}, {3'b0, data_valid}, {3'b0, e_valid});
    check1({tag, ".locked"}, {3'b0, locked}, {3'b0, m_locked});
    check1({tag, ".phase_err"}, {3'b0, phase_err}, {3'b0, e_perr});
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    e_out    = 4'h0;
    e_valid  = 1'b0;
    e_perr   = 1'b0;
    errs     = 0;
    zeros    = 0;
    anchor   = 0;
  endtask

  task automatic model_step(input logic [3:0] x);
    int ph;
    e_valid = 1'b0;
    e_perr  = 1'b0;
    if (!m_locked) begin
      if (x != 0) begin
        m_locked = 1'b1;
        anchor   = t;
        e_out    = x;
        e_valid  = 1'b1;
        errs     = 0;
        zeros    = 0;
      end
    end else begin
      ph = (t - anchor) % R;
      if (ph == 0) begin
        e_out   = x;
        e_valid = 1'b1;
        if (x != 0) begin
          errs  = 0;
          zeros = 0;
        end else begin
          zeros++;
          if (zeros == ZL) begin
            m_locked = 1'b0;
            zeros    = 0;
          end
        end
      end else if (x != 0) begin
        e_perr = 1'b1;
        errs++;
        if (errs == EL) begin
          anchor  = t;
          e_out   = x;
          e_valid = 1'b1;
          errs    = 0;
          zeros   = 0;
        end
      end
    end
  endtask

  task automatic send(input logic [3:0] x, input string tag);
    data_in = x;
    @(posedge clk);
    #1;
    model_step(x);
    check_all(tag);
    t++;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) send(4'h0, tag);
  endtask

  initial begin
    model_reset();
    t = 0;

    // Reset held while the input toggles.
    #1 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_in = 4'($urandom_range(1, 15));
      @(posedge clk);
      #1;
      check_all("reset_hold");
    end
    data_in = 4'h0;
    @(negedge clk);
    rst = 1'b0;

    // Acquisition: symbols 5, A, 3 at samples 7, 20, 33.
    idle(7, "acq");
    send(4'h5, "acq_sym5");
    check1("acq_locked_now", {3'b0, locked}, 4'h1);
    idle(12, "acq");
    send(4'hA, "acq_symA");
    idle(12, "acq");
    send(4'h3, "acq_sym3");
    idle(12, "acq");

    // Zero symbol at its slot is valid data.
    send(4'h0, "zero_sym");
    check1("zero_sym_valid", {3'b0, data_valid}, 4'h1);
    idle(12, "zero_sym");
    send(4'h6, "sym6");
    idle(12, "sym6");

    // Stream slips 4 samples late; third misaligned symbol realigns.
    idle(4, "slip");
    send(4'h7, "slip1");
    idle(12, "slip");
    send(4'h7, "slip2");
    idle(12, "slip");
    send(4'h7, "slip3_realign");
    check1("realign_both", {2'b0, data_valid, phase_err}, 4'h3);
    idle(12, "post_realign");
    send(4'h2, "post_realign_sym");
    check1("post_realign_noerr", {3'b0, phase_err}, 4'h0);

    // Sixteen zero slots drop lock; relock on 9 at an arbitrary phase.
    idle(12, "zeros");
    idle(15 * R + 1, "zeros");
    check1("lock_lost", {3'b0, locked}, 4'h0);
    idle(5, "search");
    send(4'h9, "relock9");
    check1("relock9_out", data_out, 4'h9);
    idle(5, "relock");

    // Asynchronous reset mid-period while locked.
    data_in = 4'hF;
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("async_rst_hold");
    data_in = 4'h0;
    @(negedge clk);
    rst = 1'b0;
    idle(3, "rst_relock");
    send(4'hC, "rst_relockC");
    idle(12, "rst_relock");
    send(4'hD, "rst_relockD");
    idle(12, "rst_relock");

    // Sparse random samples at random phases.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 11) == 0) send(4'($urandom_range(1, 15)), "rand_sparse");
      else send(4'h0, "rand_sparse");
    end

    // Mostly aligned random symbols with occasional jitter.
    for (int k = 0; k < 40; k++) begin
      send(4'($urandom_range(0, 15)), "rand_aligned");
      if ($urandom_range(0, 5) == 0) idle(12 + $urandom_range(1, 3), "rand_aligned");
      else idle(12, "rand_aligned");
    end

    // Long zero run to exercise lock loss from a random state.
    idle(ZL * R + 3, "rand_zero_run");
    send(4'h4, "final_relock");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
